cm0ik_ahb_ram: RTL
==================

Name: cm0ik_ahb_ram

Overview:
Parametrised AHB-Lite single-port memory slave for the Cortex-M0 integration kit. It succeeds the read-only flat model and is used for both code and data regions. It adds byte, halfword and word writes, configurable wait states, and an optional read-only mode. It also adds an ERROR response for illegal accesses and read-after-write forwarding. It sits on the MCU AHB-Lite matrix and is selected by the system decoder via HSEL.

Parameters:
ADDRWIDTH, 16, word-address width; depth = 2^ADDRWIDTH 32-bit words; byte span = 2^(ADDRWIDTH+2).
WAITSTATES, 0, wait cycles inserted in every OKAY read/write data phase, legal range 0..15.
READONLY, 0, 1 = any write transfer gets an ERROR response and memory is unchanged.
MEMBASE, 32'h00000000, base address; only HADDR - MEMBASE is decoded.

Ports:
HCLK  input  1  AHB clock, all state on rising edge
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select
HADDR  input  32  byte address
HTRANS  input  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
HSIZE  input  3  0=byte, 1=half, 2=word; others illegal
HWRITE  input  1  1=write
HWDATA  input  32  write data, valid in data phase
HREADY  input  1  bus-level ready
HRDATA  output  32  read data
HREADYOUT  output  1  slave ready
HRESP  output  1  0=OKAY, 1=ERROR

Behaviour:
- Accept: acc = HSEL & HTRANS[1] & HREADY. On an acc edge, register addr, size and write, and decide the response class (OKAY or ERR).
- ERR when any of the following holds:
  - offset = HADDR - MEMBASE >= 2^(ADDRWIDTH+2);
  - HSIZE > 2;
  - misaligned: half with offset[0]=1, or word with offset[1:0]!=0;
  - HWRITE with READONLY=1.
- State machine (data phase): IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
  - acc with OKAY and WAITSTATES=0 -> stay IDLE; data phase completes on the next edge.
  - acc with OKAY and WAITSTATES>0 -> WAIT, and the 4-bit counter loads WAITSTATES-1.
  - WAIT: HREADYOUT=0. Counter decrements each cycle. When the counter is 0, the next state is IDLE (data phase completes with HREADYOUT=1).
  - acc with ERR -> ERR1.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> IDLE. A new acc in ERR2 is processed like one in IDLE.
  - ERR transfers never read or modify memory; HRDATA holds its prior value.
- Reads:
  - Memory is read on the acc edge into HRDATA.
  - HRDATA is held stable through wait states and until the next accepted read.
- Writes:
  - Write lanes from HSIZE and addr[1:0]:
    - byte: lane = addr[1:0];
    - half: lanes {addr[1],0} and {addr[1],1};
    - word: all four lanes.
  - Memory updates on the edge where the write data phase completes (HREADYOUT=1 in that cycle). HWDATA is sampled on that edge.
  - Unselected lanes are untouched.
- Read-after-write forwarding:
  - Applies when a write data phase completes on the same edge as an accepted read to the same word.
  - HRDATA = memory word with the written lanes replaced by HWDATA lanes. There is no extra wait.
- IDLE/BUSY transfers and unselected cycles: zero-wait OKAY, no memory activity.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=32'h0, state=IDLE, counter=0, no pending write.
- Memory contents are not reset.
- Reset asserted mid-transfer: any pending write is discarded (memory unchanged) and outputs return to reset values.
- Back-to-back transfers: pipelined per AHB-Lite. New acc can only occur while HREADY=1, so there is never overlap within WAIT or ERR1.
- Address wrap: offset is computed modulo 2^32. Addresses below MEMBASE wrap to large offsets and therefore produce ERR.

Test Plan:
1. WAITSTATES=0: write word 32'hDEADBEEF @0x10, then read @0x10 -> HRDATA=32'hDEADBEEF, HREADYOUT=1 in every cycle.
2. Byte/half writes: word @0x20 = 32'h00000000; byte 8'hAA @0x21; half 16'h5566 @0x22 -> read @0x20 returns 32'h5566AA00.
3. Back-to-back write 32'h12345678 @0x40 then read @0x40 (forwarding path) -> HRDATA=32'h12345678 in the first read data phase.
4. WAITSTATES=3: read -> exactly 3 cycles of HREADYOUT=0, then HREADYOUT=1 with valid data. Drop HSEL mid-wait: no effect.
5. ERROR cases, each giving a 2-cycle response (HREADYOUT 0 then 1, HRESP=1) with memory unchanged on read-back:
   - word read @0x02 (misaligned);
   - HSIZE=3;
   - offset 2^(ADDRWIDTH+2);
   - write with READONLY=1.
6. Assert HRESETn in WAIT of a write: HREADYOUT=1, HRESP=0, HRDATA=0 immediately; target word retains its old value.

Source files
------------

// File: rtl/cm0ik_ahb_ram.sv
// AHB-Lite single-port RAM slave with byte/half/word writes, configurable wait states,
// optional read-only mode, ERROR responses for illegal accesses and read-after-write forwarding.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready, OKAY; a pending write (if any) commits on this edge
// WAIT   | OKAY data phase stalled, r_cnt counts remaining waits
// ERR1   | first ERROR cycle, HREADYOUT low
// ERR2   | second ERROR cycle, HREADYOUT high; may accept a new transfer
module cm0ik_ahb_ram #(
    parameter int          ADDRWIDTH  = 16,
    parameter int          WAITSTATES = 0,
    parameter int          READONLY   = 0,
    parameter logic [31:0] MEMBASE    = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    localparam logic [3:0]  WS_LOAD = 4'(WAITSTATES - 1);
    localparam logic [32:0] SPAN    = 33'(1) << (ADDRWIDTH + 2);

    logic [31:0] r_mem [0:(2**ADDRWIDTH)-1];

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic                 r_wpend;
    logic [ADDRWIDTH-1:0] r_idx;
    logic [3:0]           r_lanes;
    logic [31:0]          r_rdata;

    logic [31:0]          w_off;
    logic [ADDRWIDTH-1:0] w_idx;
    logic                 w_ready;
    logic                 w_acc;
    logic                 w_err;
    logic                 w_wr;
    logic [3:0]           w_lanes;
    logic [31:0]          w_rd_fwd;

    // Offset wraps modulo 2^32, so addresses below MEMBASE land out of range.
    assign w_off   = HADDR - MEMBASE;
    assign w_idx   = w_off[ADDRWIDTH+1:2];
    assign w_ready = (r_state == S_IDLE) || (r_state == S_ERR2);
    assign w_acc   = HSEL && ((HTRANS == 2'b10) || (HTRANS == 2'b11)) && HREADY && w_ready;

    assign w_err = ({1'b0, w_off} >= SPAN)
                 || (HSIZE > 3'd2)
                 || ((HSIZE == 3'd1) && w_off[0])
                 || ((HSIZE == 3'd2) && (w_off[1:0] != 2'b00))
                 || (HWRITE && (READONLY != 0));

    always_comb begin
        w_lanes = 4'b0000;
        case (HSIZE)
            3'd0:    w_lanes = 4'b0001 << w_off[1:0];
            3'd1:    w_lanes = w_off[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_lanes = 4'b1111;
            default: w_lanes = 4'b0000;
        endcase
    end

    // A pending write only ever sits in IDLE (zero-wait) or reaches IDLE after WAIT.
    assign w_wr = r_wpend && (r_state == S_IDLE);

    always_comb begin
        w_rd_fwd = r_mem[w_idx];
        if (w_wr && (r_idx == w_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (r_lanes[b]) begin
                    w_rd_fwd[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (r_lanes[b]) begin
                    r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_wpend <= 1'b0;
            r_idx   <= '0;
            r_lanes <= 4'b0000;
            r_rdata <= 32'h0;
        end else begin
            if (w_wr) begin
                r_wpend <= 1'b0;
            end

            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1:  r_state <= S_ERR2;
                default: r_state <= S_IDLE;
            endcase

            if (w_acc) begin
                if (w_err) begin
                    r_state <= S_ERR1;
                    r_wpend <= 1'b0;
                end else begin
                    if (WAITSTATES > 0) begin
                        r_state <= S_WAIT;
                        r_cnt   <= WS_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                    r_wpend <= HWRITE;
                    r_idx   <= w_idx;
                    r_lanes <= w_lanes;
                    if (!HWRITE) begin
                        r_rdata <= w_rd_fwd;
                    end
                end
            end
        end
    end

    assign HRDATA    = r_rdata;
    assign HREADYOUT = w_ready;
    assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);

endmodule
